iir_bp_biquad_mc: RTL

Multi-channel, time-multiplexed digital biquad band-pass filter: the sampled-data successor of the single-channel active op-amp band-pass stage in the analog front end. One shared multiplier-accumulator processes up to CHANNELS independent streams. Each channel keeps its own history. All channels share one programmable coefficient set. The block sits between the ADC sample stream and the downstream detector, with valid/ready handshakes on both sides.

---
 rtl/iir_bp_biquad_mc_if.sv | 33 +++
 rtl/iir_bp_biquad_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iir_bp_biquad_mc_if.sv
// Bus bundle for iir_bp_biquad_mc: coefficient port, history clear, sample in/out streams, FSM debug.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
// the source holds valid and its payload stable until that edge, and ready never waits on valid.
interface iir_bp_biquad_mc_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int CH_W   = 2
);
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              hist_clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_sat;
    logic [2:0]        dbg_state;

    modport master (
        output coef_we, coef_addr, coef_data, hist_clr, in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_sat, dbg_state
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, hist_clr, in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_sat, dbg_state
    );
endinterface

// File: rtl/iir_bp_biquad_mc.sv
// Time-multiplexed multi-channel band-pass biquad: one shared MAC, per-channel history, shared coefficients.
// Optional output saturation is enabled by defining IIR_BP_SAT_EN; otherwise results wrap.
module iir_bp_biquad_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 18,
    parameter int FRAC     = 14,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic              clk,
    input logic              rst,
    iir_bp_biquad_mc_if.slave bus
);
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B0   = 3'd1;
    localparam logic [2:0] S_B2   = 3'd2;
    localparam logic [2:0] S_A1   = 3'd3;
    localparam logic [2:0] S_A2   = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]               state_q, state_d;
    logic signed [COEF_W-1:0] coef_q [4];
    logic signed [COEF_W-1:0] coef_d [4];
    logic signed [COEF_W-1:0] shd_q [4];
    logic signed [COEF_W-1:0] shd_d [4];
    logic signed [DATA_W-1:0] x_q, x_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x1_q [CHANNELS];
    logic signed [DATA_W-1:0] x1_d [CHANNELS];
    logic signed [DATA_W-1:0] x2_q [CHANNELS];
    logic signed [DATA_W-1:0] x2_d [CHANNELS];
    logic signed [DATA_W-1:0] y1_q [CHANNELS];
    logic signed [DATA_W-1:0] y1_d [CHANNELS];
    logic signed [DATA_W-1:0] y2_q [CHANNELS];
    logic signed [DATA_W-1:0] y2_d [CHANNELS];
    logic                     clr_pend_q, clr_pend_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [COEF_W-1:0] mul_c;
    logic signed [DATA_W-1:0] mul_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] red_data;
    logic                     red_sat;
    logic                     clr_now;

    // Operand select for the shared multiplier; the shadow set keeps mid-sample writes out.
    always_comb begin
        mul_c = shd_q[0];
        mul_x = x_q;
        case (state_q)
            S_B2: begin
                mul_c = shd_q[1];
                mul_x = x2_q[ch_q];
            end
            S_A1: begin
                mul_c = shd_q[2];
                mul_x = y1_q[ch_q];
            end
            S_A2: begin
                mul_c = shd_q[3];
                mul_x = y2_q[ch_q];
            end
            default: ;
        endcase
    end

    assign prod    = PROD_W'(mul_c) * PROD_W'(mul_x);
    assign acc_sum = (state_q == S_A1 || state_q == S_A2) ? acc_q - ACC_W'(prod)
                                                            : acc_q + ACC_W'(prod);

`ifdef IIR_BP_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_sum >>> FRAC;

    always_comb begin
        red_sat  = 1'b0;
        red_data = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            red_data = SAT_MAX[DATA_W-1:0];
            red_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            red_data = SAT_MIN[DATA_W-1:0];
            red_sat  = 1'b1;
        end
    end
`else
    assign red_data = DATA_W'(acc_sum >>> FRAC);
    assign red_sat  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        shd_d       = shd_q;
        x_d         = x_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        clr_pend_d  = clr_pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_sat_d   = out_sat_q;
        clr_now     = 1'b0;

        if (bus.coef_we) coef_d[bus.coef_addr] = bus.coef_data;
        if (state_q != S_IDLE && bus.hist_clr) clr_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                clr_now = bus.hist_clr;
                // Samples tagged for a nonexistent channel are accepted and dropped.
                if (bus.in_valid && (32'(bus.in_ch) < CHANNELS)) begin
                    x_d     = bus.in_data;
                    ch_d    = bus.in_ch;
                    shd_d   = coef_q;
                    acc_d   = '0;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                acc_d   = acc_sum;
                state_d = S_B2;
            end
            S_B2: begin
                acc_d   = acc_sum;
                state_d = S_A1;
            end
            S_A1: begin
                acc_d   = acc_sum;
                state_d = S_A2;
            end
            S_A2: begin
                acc_d       = acc_sum;
                out_valid_d = 1'b1;
                out_data_d  = red_data;
                out_ch_d    = ch_q;
                out_sat_d   = red_sat;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    x2_d[ch_q]  = x1_q[ch_q];
                    x1_d[ch_q]  = x_q;
                    y2_d[ch_q]  = y1_q[ch_q];
                    y1_d[ch_q]  = out_data_q;
                    clr_now     = clr_pend_q || bus.hist_clr;
                    clr_pend_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A deferred clear lands after the history update of the sample that was in flight.
        if (clr_now) begin
            for (int i = 0; i < CHANNELS; i++) begin
                x1_d[i] = '0;
                x2_d[i] = '0;
                y1_d[i] = '0;
                y2_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            coef_q      <= '{default: '0};
            shd_q       <= '{default: '0};
            x_q         <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            clr_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            shd_q       <= shd_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            clr_pend_q  <= clr_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.dbg_state = state_q;
endmodule
